// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared constants, state encoding and requantizer for the FC engine
package fc_pkg;
    localparam int WEIGHT_WIDTH           = 4;
    localparam int WEIGHT_NUM             = 20;
    localparam int DATA_WIDTH             = 8;
    localparam int DATA_NUM_PER_SRAM_ADDR = 4;
    localparam int WEIGHT_ADDR_WIDTH      = 15;
    localparam int FC1_SHIFT              = 7;
    localparam int FC2_SHIFT              = 7;

    localparam int FC1_IN    = 800;
    localparam int FC1_OUT   = 500;
    localparam int FC2_IN    = 500;
    localparam int FC2_OUT   = 10;
    localparam int FC1_WPN   = 40;
    localparam int FC2_WPN   = 25;
    localparam int FC2_WBASE = 20000;

    // 20 products of at most |128*8| fit comfortably in 16 signed bits
    localparam int SUM_WIDTH = 16;
    localparam int ACC_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE, ST_FC1, ST_FC1_FLUSH, ST_FC2, ST_FC2_FLUSH, ST_DONE
    } fc_state_t;

    function automatic logic [DATA_WIDTH-1:0] requant(input logic signed [ACC_WIDTH-1:0] acc,
                                                      input int shift, input logic relu);
        logic signed [ACC_WIDTH-1:0] s;
        s = acc >>> shift;
        if (s > 32'sd127) return 8'd127;
        if (relu && s < 32'sd0) return 8'd0;
        if (s < -32'sd128) return 8'h80;
        return s[DATA_WIDTH-1:0];
    endfunction
endpackage

// File: rtl/fc_layer_top_mac20.sv
// rtl/fc_layer_top_mac20.sv - 20-lane signed 8x4 multiply with adder tree, registered sum
module fc_mac20
    import fc_pkg::*;
(
    input  logic                                clk,
    input  logic                                srstn,
    input  logic [WEIGHT_NUM*DATA_WIDTH-1:0]    act,
    input  logic [WEIGHT_NUM*WEIGHT_WIDTH-1:0]  weight,
    output logic signed [SUM_WIDTH-1:0]         sum
);
    logic signed [SUM_WIDTH-1:0] tree;

    always_comb begin
        logic signed [SUM_WIDTH-1:0] a_ext;
        logic signed [SUM_WIDTH-1:0] w_ext;
        tree  = '0;
        a_ext = '0;
        w_ext = '0;
        for (int m = 0; m < WEIGHT_NUM; m++) begin
            a_ext = SUM_WIDTH'($signed(act[m*DATA_WIDTH +: DATA_WIDTH]));
            w_ext = SUM_WIDTH'($signed(weight[m*WEIGHT_WIDTH +: WEIGHT_WIDTH]));
            tree  = tree + a_ext * w_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (srstn) sum <= '0;
        else       sum <= tree;
    end
endmodule

// File: rtl/fc_layer_top.sv
// rtl/fc_layer_top.sv - two-layer fully-connected engine: FC1 800->500, FC2 500->10
module fc_layer_top
    import fc_pkg::*;
(
    input  logic        clk,
    input  logic        srstn,
    input  logic        conv_done,
    input  logic        mem_sel,
    input  logic [31:0] sram_rdata_c0, sram_rdata_c1, sram_rdata_c2, sram_rdata_c3, sram_rdata_c4,
    output logic [9:0]  sram_raddr_c0, sram_raddr_c1, sram_raddr_c2, sram_raddr_c3, sram_raddr_c4,
    input  logic [31:0] sram_rdata_d0, sram_rdata_d1, sram_rdata_d2, sram_rdata_d3, sram_rdata_d4,
    output logic [9:0]  sram_raddr_d0, sram_raddr_d1, sram_raddr_d2, sram_raddr_d3, sram_raddr_d4,
    input  logic [31:0] sram_rdata_e0, sram_rdata_e1, sram_rdata_e2, sram_rdata_e3, sram_rdata_e4,
    output logic [9:0]  sram_raddr_e0, sram_raddr_e1, sram_raddr_e2, sram_raddr_e3, sram_raddr_e4,
    output logic        sram_write_enable_e0, sram_write_enable_e1, sram_write_enable_e2,
    output logic        sram_write_enable_e3, sram_write_enable_e4,
    output logic [3:0]  sram_bytemask_e,
    output logic [9:0]  sram_waddr_e,
    output logic [7:0]  sram_wdata_e,
    output logic        sram_write_enable_f,
    output logic [3:0]  sram_bytemask_f,
    output logic [9:0]  sram_waddr_f,
    output logic [7:0]  sram_wdata_f,
    input  logic [WEIGHT_NUM*WEIGHT_WIDTH-1:0] sram_rdata_weight,
    output logic [WEIGHT_ADDR_WIDTH-1:0]       sram_raddr_weight,
    output logic        fc1_done,
    output logic        fc2_done
);
    fc_state_t state;
    logic sel_c, is_fc2;
    logic [8:0] n_cnt;
    logic [5:0] j_cnt;
    logic [WEIGHT_ADDR_WIDTH-1:0] w_ptr;
    logic [9:0] act_raddr, e_raddr;
    logic s0_valid, s0_first, s0_last, s1_valid, s1_first, s1_last, s2_valid, s2_first, s2_last;
    logic [1:0] w_lane;
    logic [2:0] w_bank;
    logic [9:0] w_addr, w_cnt;
    logic [4:0] we_e;
    logic signed [ACC_WIDTH-1:0] acc, acc_next;
    logic signed [SUM_WIDTH-1:0] mac_sum;
    logic [WEIGHT_NUM*DATA_WIDTH-1:0] mac_act;
    logic [4:0][31:0] c_word, d_word, e_word, bank_word;
    logic [DATA_WIDTH-1:0] q;
    logic [5:0] j_last;
    logic [8:0] n_last;

    assign {sram_raddr_c4, sram_raddr_c3, sram_raddr_c2, sram_raddr_c1, sram_raddr_c0} = {5{act_raddr}};
    assign {sram_raddr_d4, sram_raddr_d3, sram_raddr_d2, sram_raddr_d1, sram_raddr_d0} = {5{act_raddr}};
    assign {sram_raddr_e4, sram_raddr_e3, sram_raddr_e2, sram_raddr_e1, sram_raddr_e0} = {5{e_raddr}};
    assign {sram_write_enable_e4, sram_write_enable_e3, sram_write_enable_e2,
            sram_write_enable_e1, sram_write_enable_e0} = we_e;

    assign c_word = {sram_rdata_c4, sram_rdata_c3, sram_rdata_c2, sram_rdata_c1, sram_rdata_c0};
    assign d_word = {sram_rdata_d4, sram_rdata_d3, sram_rdata_d2, sram_rdata_d1, sram_rdata_d0};
    assign e_word = {sram_rdata_e4, sram_rdata_e3, sram_rdata_e2, sram_rdata_e1, sram_rdata_e0};
    assign bank_word = is_fc2 ? e_word : (sel_c ? c_word : d_word);

    // lane 0 is the most significant byte; activation 4b+l pairs with weight nibble 4b+l
    always_comb begin
        mac_act = '0;
        for (int b = 0; b < 5; b++)
            for (int l = 0; l < DATA_NUM_PER_SRAM_ADDR; l++)
                mac_act[(4*b+l)*DATA_WIDTH +: DATA_WIDTH] = bank_word[b][31-8*l -: 8];
    end

    fc_mac20 u_mac (
        .clk    (clk),
        .srstn  (srstn),
        .act    (mac_act),
        .weight (sram_rdata_weight),
        .sum    (mac_sum)
    );

    assign acc_next = (s2_first ? 32'sd0 : acc) + ACC_WIDTH'(mac_sum);
    assign q        = requant(acc_next, is_fc2 ? FC2_SHIFT : FC1_SHIFT, !is_fc2);
    assign j_last   = is_fc2 ? 6'(FC2_WPN-1) : 6'(FC1_WPN-1);
    assign n_last   = is_fc2 ? 9'(FC2_OUT-1) : 9'(FC1_OUT-1);

    always_ff @(posedge clk) begin
        if (srstn) begin
            state <= ST_IDLE;
            sel_c <= 1'b0;  is_fc2 <= 1'b0;
            n_cnt <= '0;  j_cnt <= '0;  w_ptr <= '0;
            sram_raddr_weight <= '0;  act_raddr <= '0;  e_raddr <= '0;
            {s0_valid, s0_first, s0_last} <= '0;
            {s1_valid, s1_first, s1_last} <= '0;
            {s2_valid, s2_first, s2_last} <= '0;
            w_lane <= '0;  w_bank <= '0;  w_addr <= '0;  w_cnt <= '0;
            we_e <= 5'h1F;  sram_bytemask_e <= 4'hF;  sram_waddr_e <= '0;  sram_wdata_e <= '0;
            sram_write_enable_f <= 1'b1;  sram_bytemask_f <= 4'hF;  sram_waddr_f <= '0;  sram_wdata_f <= '0;
            fc1_done <= 1'b0;  fc2_done <= 1'b0;
            acc <= '0;
        end else begin
            we_e <= 5'h1F;
            sram_bytemask_e <= 4'hF;
            sram_write_enable_f <= 1'b1;
            sram_bytemask_f <= 4'hF;
            s0_valid <= 1'b0;
            {s1_valid, s1_first, s1_last} <= {s0_valid, s0_first, s0_last};
            {s2_valid, s2_first, s2_last} <= {s1_valid, s1_first, s1_last};

            if (s2_valid) begin
                acc <= acc_next;
                if (s2_last) begin
                    w_cnt  <= w_cnt + 1'b1;
                    w_lane <= w_lane + 1'b1;
                    if (!is_fc2) begin
                        we_e[w_bank]    <= 1'b0;
                        sram_bytemask_e <= ~(4'b1000 >> w_lane);
                        sram_waddr_e    <= w_addr;
                        sram_wdata_e    <= q;
                        if (w_lane == 2'd3) begin
                            if (w_bank == 3'd4) begin
                                w_bank <= '0;
                                w_addr <= w_addr + 1'b1;
                            end else begin
                                w_bank <= w_bank + 1'b1;
                            end
                        end
                    end else begin
                        sram_write_enable_f <= 1'b0;
                        sram_bytemask_f     <= ~(4'b1000 >> w_lane);
                        sram_waddr_f        <= w_addr;
                        sram_wdata_f        <= q;
                        if (w_lane == 2'd3) w_addr <= w_addr + 1'b1;
                    end
                end
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (conv_done) begin
                        state <= ST_FC1;
                        fc1_done <= 1'b0;  fc2_done <= 1'b0;
                        sel_c <= mem_sel;  is_fc2 <= 1'b0;
                        w_ptr <= '0;  n_cnt <= '0;  j_cnt <= '0;
                        w_lane <= '0;  w_bank <= '0;  w_addr <= '0;  w_cnt <= '0;
                    end
                end
                ST_FC1, ST_FC2: begin
                    sram_raddr_weight <= w_ptr;
                    w_ptr <= w_ptr + 1'b1;
                    if (is_fc2) e_raddr   <= 10'(j_cnt);
                    else        act_raddr <= 10'(j_cnt);
                    s0_valid <= 1'b1;
                    s0_first <= (j_cnt == '0);
                    s0_last  <= (j_cnt == j_last);
                    if (j_cnt == j_last) begin
                        j_cnt <= '0;
                        n_cnt <= n_cnt + 1'b1;
                        if (n_cnt == n_last) state <= is_fc2 ? ST_FC2_FLUSH : ST_FC1_FLUSH;
                    end else begin
                        j_cnt <= j_cnt + 1'b1;
                    end
                end
                ST_FC1_FLUSH: begin
                    // the final e write is on the bus this cycle and commits at this edge
                    if (w_cnt == 10'(FC1_OUT)) begin
                        state <= ST_FC2;
                        fc1_done <= 1'b1;
                        is_fc2 <= 1'b1;
                        w_ptr <= WEIGHT_ADDR_WIDTH'(FC2_WBASE);
                        n_cnt <= '0;  j_cnt <= '0;
                        w_lane <= '0;  w_bank <= '0;  w_addr <= '0;  w_cnt <= '0;
                    end
                end
                ST_FC2_FLUSH: begin
                    if (w_cnt == 10'(FC2_OUT)) begin
                        sram_write_enable_f <= 1'b0;
                        sram_bytemask_f     <= 4'b1100;
                        sram_waddr_f        <= 10'(FC2_OUT / 4);
                        sram_wdata_f        <= '0;
                        w_cnt <= w_cnt + 1'b1;
                    end else if (w_cnt == 10'(FC2_OUT + 1)) begin
                        state <= ST_DONE;
                        fc2_done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fc_layer_top.sv
// tb/tb_fc_layer_top.sv - self-checking bench for fc_layer_top against an arithmetic model
module tb_fc_layer_top;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic srstn, conv_done, mem_sel;
    logic [31:0] rd_c [5];
    logic [31:0] rd_d [5];
    logic [31:0] rd_e [5];
    logic [9:0]  ra_c [5];
    logic [9:0]  ra_d [5];
    logic [9:0]  ra_e [5];
    logic [4:0]  we_e;
    logic [3:0]  bm_e, bm_f;
    logic [9:0]  wa_e, wa_f;
    logic [7:0]  wd_e, wd_f;
    logic        we_f;
    logic [79:0] rd_w;
    logic [14:0] ra_w;
    logic        fc1_done, fc2_done;

    logic [31:0] c_mem [5][1024];
    logic [31:0] d_mem [5][1024];
    logic [31:0] e_mem [5][1024];
    logic [31:0] f_mem [1024];
    logic [79:0] w_mem [20250];

    int exp1 [500];
    int exp2 [10];
    int total = 0;
    int bad = 0;

    fc_layer_top dut (
        .clk(clk), .srstn(srstn), .conv_done(conv_done), .mem_sel(mem_sel),
        .sram_rdata_c0(rd_c[0]), .sram_rdata_c1(rd_c[1]), .sram_rdata_c2(rd_c[2]),
        .sram_rdata_c3(rd_c[3]), .sram_rdata_c4(rd_c[4]),
        .sram_raddr_c0(ra_c[0]), .sram_raddr_c1(ra_c[1]), .sram_raddr_c2(ra_c[2]),
        .sram_raddr_c3(ra_c[3]), .sram_raddr_c4(ra_c[4]),
        .sram_rdata_d0(rd_d[0]), .sram_rdata_d1(rd_d[1]), .sram_rdata_d2(rd_d[2]),
        .sram_rdata_d3(rd_d[3]), .sram_rdata_d4(rd_d[4]),
        .sram_raddr_d0(ra_d[0]), .sram_raddr_d1(ra_d[1]), .sram_raddr_d2(ra_d[2]),
        .sram_raddr_d3(ra_d[3]), .sram_raddr_d4(ra_d[4]),
        .sram_rdata_e0(rd_e[0]), .sram_rdata_e1(rd_e[1]), .sram_rdata_e2(rd_e[2]),
        .sram_rdata_e3(rd_e[3]), .sram_rdata_e4(rd_e[4]),
        .sram_raddr_e0(ra_e[0]), .sram_raddr_e1(ra_e[1]), .sram_raddr_e2(ra_e[2]),
        .sram_raddr_e3(ra_e[3]), .sram_raddr_e4(ra_e[4]),
        .sram_write_enable_e0(we_e[0]), .sram_write_enable_e1(we_e[1]),
        .sram_write_enable_e2(we_e[2]), .sram_write_enable_e3(we_e[3]),
        .sram_write_enable_e4(we_e[4]),
        .sram_bytemask_e(bm_e), .sram_waddr_e(wa_e), .sram_wdata_e(wd_e),
        .sram_write_enable_f(we_f), .sram_bytemask_f(bm_f),
        .sram_waddr_f(wa_f), .sram_wdata_f(wd_f),
        .sram_rdata_weight(rd_w), .sram_raddr_weight(ra_w),
        .fc1_done(fc1_done), .fc2_done(fc2_done)
    );

    // SRAM models: one-cycle read latency, active-low byte-masked writes
    always @(posedge clk) begin
        for (int b = 0; b < 5; b++) begin
            rd_c[b] <= c_mem[b][ra_c[b]];
            rd_d[b] <= d_mem[b][ra_d[b]];
            rd_e[b] <= e_mem[b][ra_e[b]];
            if (!we_e[b])
                for (int k = 0; k < 4; k++)
                    if (!bm_e[k]) e_mem[b][wa_e][8*k +: 8] <= wd_e;
        end
        rd_w <= w_mem[ra_w];
        if (!we_f)
            for (int k = 0; k < 4; k++)
                if (!bm_f[k]) f_mem[wa_f][8*k +: 8] <= wd_f;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic int wt(input int addr, input int m);
        logic [79:0] word;
        word = w_mem[addr];
        return int'($signed(word[4*m +: 4]));
    endfunction

    task automatic run_model(input logic use_c);
        int a [800];
        int acc, r;
        logic [31:0] word;
        for (int i = 0; i < 800; i++) begin
            word = use_c ? c_mem[(i/4)%5][i/20] : d_mem[(i/4)%5][i/20];
            a[i] = int'($signed(word[31-8*(i%4) -: 8]));
        end
        for (int n = 0; n < 500; n++) begin
            acc = 0;
            for (int i = 0; i < 800; i++) acc += a[i] * wt(40*n + i/20, i%20);
            r = acc >>> 7;
            if (r < 0) r = 0;
            if (r > 127) r = 127;
            exp1[n] = r;
        end
        for (int n = 0; n < 10; n++) begin
            acc = 0;
            for (int i = 0; i < 500; i++) acc += exp1[i] * wt(20000 + 25*n + i/20, i%20);
            r = acc >>> 7;
            if (r < -128) r = -128;
            if (r > 127) r = 127;
            exp2[n] = r;
        end
    endtask

    task automatic check_results(input string tag);
        logic [31:0] expw;
        int idx;
        for (int a = 0; a < 25; a++)
            for (int b = 0; b < 5; b++) begin
                for (int l = 0; l < 4; l++) expw[31-8*l -: 8] = 8'(exp1[20*a + 4*b + l]);
                chk($sformatf("%s_e%0d_addr%0d", tag, b, a), e_mem[b][a], expw);
            end
        for (int a = 0; a < 3; a++) begin
            for (int l = 0; l < 4; l++) begin
                idx = 4*a + l;
                expw[31-8*l -: 8] = (idx < 10) ? 8'(exp2[idx]) : 8'h00;
            end
            chk($sformatf("%s_f_addr%0d", tag, a), f_mem[a], expw);
        end
    endtask

    task automatic run_fc(input logic sel, input int glitch_at);
        int cyc;
        mem_sel = sel;
        conv_done = 1'b1;
        step();
        conv_done = 1'b0;
        cyc = 1;
        while (fc1_done !== 1'b1 && cyc < 20100) begin
            conv_done = (cyc == glitch_at);
            step();
            cyc++;
        end
        conv_done = 1'b0;
        chk("fc1_done_within_20100", 32'(fc1_done), 32'd1);
        chk("fc2_done_low_at_fc1_done", 32'(fc2_done), 32'd0);
        cyc = 0;
        while (fc2_done !== 1'b1 && cyc < 300) begin
            step();
            cyc++;
        end
        chk("fc2_done_within_300", 32'(fc2_done), 32'd1);
        step();
        chk("fc1_done_level", 32'(fc1_done), 32'd1);
        chk("fc2_done_level", 32'(fc2_done), 32'd1);
    endtask

    initial begin
        srstn = 1'b1;
        conv_done = 1'b0;
        mem_sel = 1'b0;
        repeat (3) step();
        chk("rst_we_e", 32'(we_e), 32'h1F);
        chk("rst_we_f", 32'(we_f), 32'd1);
        chk("rst_bm_e", 32'(bm_e), 32'hF);
        chk("rst_bm_f", 32'(bm_f), 32'hF);
        chk("rst_ra_w", 32'(ra_w), 32'd0);
        chk("rst_ra_c0", 32'(ra_c[0]), 32'd0);
        chk("rst_ra_e4", 32'(ra_e[4]), 32'd0);
        chk("rst_wa_e", 32'(wa_e), 32'd0);
        chk("rst_wd_f", 32'(wd_f), 32'd0);
        chk("rst_fc1_done", 32'(fc1_done), 32'd0);
        chk("rst_fc2_done", 32'(fc2_done), 32'd0);
        srstn = 1'b0;
        step();

        // all-ones activations and weights from the c banks; d banks hold noise
        for (int b = 0; b < 5; b++)
            for (int a = 0; a < 1024; a++) begin
                c_mem[b][a] = 32'h01010101;
                d_mem[b][a] = $urandom;
            end
        for (int i = 0; i < 20250; i++) w_mem[i] = {20{4'h1}};
        run_model(1'b1);
        run_fc(1'b1, 0);
        check_results("ones");
        chk("ones_e0_const", e_mem[0][0], 32'h06060606);
        chk("ones_f0_const", f_mem[0], 32'h17171717);
        chk("ones_f1_const", f_mem[1], 32'h17171717);
        chk("ones_f2_const", f_mem[2], 32'h17170000);

        // random golden pattern from the d banks, with a stray conv_done while busy
        for (int b = 0; b < 5; b++)
            for (int a = 0; a < 1024; a++) begin
                c_mem[b][a] = $urandom;
                d_mem[b][a] = $urandom;
            end
        for (int i = 0; i < 20250; i++) w_mem[i] = {$urandom, $urandom, 16'($urandom)};
        run_model(1'b0);
        run_fc(1'b0, 1000);
        check_results("rand_d");

        // saturation pattern, aborted by reset mid-FC1, then rerun to completion
        for (int b = 0; b < 5; b++)
            for (int a = 0; a < 1024; a++) c_mem[b][a] = 32'h7F7F7F7F;
        for (int i = 0; i < 20250; i++) w_mem[i] = {20{4'h7}};
        run_model(1'b1);
        mem_sel = 1'b1;
        conv_done = 1'b1;
        step();
        conv_done = 1'b0;
        repeat (5000) step();
        srstn = 1'b1;
        step();
        chk("abort_fc1_done", 32'(fc1_done), 32'd0);
        chk("abort_fc2_done", 32'(fc2_done), 32'd0);
        chk("abort_we_e", 32'(we_e), 32'h1F);
        chk("abort_we_f", 32'(we_f), 32'd1);
        chk("abort_ra_w", 32'(ra_w), 32'd0);
        srstn = 1'b0;
        step();
        run_fc(1'b1, 0);
        check_results("sat");
        chk("sat_f2_const", f_mem[2], 32'h7F7F0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fc_layer_top.md
Name: fc_layer_top

Overview:
- Two-layer fully-connected engine placed after CONV2/POOL2.
- FC1: 800 int8 activations (banks c0-c4 or d0-d4) x 4-bit weights -> 500 int8 outputs, written to banks e0-e4.
- FC2: reads those 500 outputs back from e0-e4 -> 10 int8 scores, written to bank f.
- 20 MACs per cycle, one 80-bit weight word per cycle. Weights come from a 20250x80b SRAM; activation SRAMs are 128x32b.

Parameters:
- WEIGHT_WIDTH, 4, bits per signed weight.
- WEIGHT_NUM, 20, weights per weight word (weight word = 80 bits).
- DATA_WIDTH, 8, bits per signed activation.
- DATA_NUM_PER_SRAM_ADDR, 4, activations per 32-bit SRAM word.
- WEIGHT_ADDR_WIDTH, 15, weight address width.
- FC1_SHIFT, 7, arithmetic right shift applied to FC1 accumulators.
- FC2_SHIFT, 7, arithmetic right shift applied to FC2 accumulators.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- srstn  in  1  synchronous reset, active-high.
- conv_done  in  1  one-cycle start pulse.
- mem_sel  in  1  FC1 input source, sampled at start: 1 = c banks, 0 = d banks.
- sram_rdata_c0..c4  in  32 each  c-bank read data.
- sram_raddr_c0..c4  out  10 each  c-bank read addresses.
- sram_rdata_d0..d4  in  32 each  d-bank read data.
- sram_raddr_d0..d4  out  10 each  d-bank read addresses.
- sram_rdata_e0..e4  in  32 each  e-bank read data (FC2 input).
- sram_raddr_e0..e4  out  10 each  e-bank read addresses.
- sram_write_enable_e0..e4  out  1 each  active-low byte write strobe per e bank.
- sram_bytemask_e  out  4  active-low lane mask; bit k selects bits [8k+7:8k].
- sram_waddr_e  out  10  e write address.
- sram_wdata_e  out  8  e write byte.
- sram_write_enable_f  out  1  active-low write strobe for bank f.
- sram_bytemask_f  out  4  active-low lane mask for bank f.
- sram_waddr_f  out  10  f write address.
- sram_wdata_f  out  8  f write byte.
- sram_rdata_weight  in  80  weight word.
- sram_raddr_weight  out  15  weight read address.
- fc1_done  out  1  high when FC1 is complete.
- fc2_done  out  1  high when FC2 is complete.

Behaviour:
- SRAM read latency: all SRAMs return data one cycle after the address is presented.
- Data layout: byte lane l=0 is bits [31:24], l=3 is bits [7:0].
  - Address j, bank b, lane l holds activation 20j+4b+l.
  - That activation pairs with weight m=4b+l, taken from bits [4m+3:4m] of the weight word.
- FC1 read schedule: for neuron n=0..499 and j=0..39:
  - sram_raddr_weight = 40n+j;
  - the selected bank set (c or d) is read at address j.
- FC2 read schedule: for neuron n=0..9 and j=0..24:
  - sram_raddr_weight = 20000+25n+j;
  - e0..e4 are read at address j.
- Arithmetic:
  - signed 8b x signed 4b products, summed through a 20-input adder tree;
  - 32-bit signed accumulator, cleared at the start of each neuron; no bias.
  - FC1 result: acc >>> FC1_SHIFT, then ReLU, then clamp to [0,127].
  - FC2 result: acc >>> FC2_SHIFT, then clamp to [-128,127].
- FC1 write: neuron n goes to bank (n/4)%5, address n/20, lane n%4.
  - Drive bytemask = ~(4'b1000>>lane) and the matching write_enable_e low for exactly one cycle.
- FC2 write: score n goes to bank f, address n/4, lane n%4.
  - After score 9, write 0 to lanes 2 and 3 of address 2.
- Neurons are pipelined back-to-back.
  - FC1 ≤ 20,100 cycles from start to fc1_done.
  - FC2 ≤ 300 cycles after fc1_done.
- FSM: IDLE -> FC1 -> FC1_FLUSH -> FC2 -> FC2_FLUSH -> DONE.
  - IDLE->FC1 on conv_done; clears both done flags.
  - FC1_FLUSH: last FC1 write committed -> set fc1_done; FC2 then starts automatically.
  - FC2_FLUSH: final f write committed -> set fc2_done.
  - DONE->FC1 on a new conv_done.
  - conv_done is ignored while busy.
- Done flags are levels: stay high until reset or the next start.
- Reset (including mid-operation):
  - state IDLE; all addresses 0; all write enables 1; bytemasks 4'hF; wdata 0; done flags 0; accumulators 0.

Decomposition:
- Shared package fc_pkg holds:
  - FC1_IN=800, FC1_OUT=500, FC2_IN=500, FC2_OUT=10;
  - FC1_WPN=40, FC2_WPN=25;
  - FC2_WBASE=20000;
  - the FSM state enum.
- One sub-module, fc_mac20: combinational 20-lane 8x4 signed multiply plus adder tree, registered output.
- Top level holds the FSM, counters, accumulator, requantizer and write-address generation.

Test Plan:
- All activations 1, all weights 1 (mem_sel=1): FC1 acc 800 >>> 7 = 6 -> every e byte 0x06. FC2 acc 3000 >>> 7 = 23 -> f words 0x17171717, 0x17171717, 0x17170000.
- Weights -1, activations 1: FC1 outputs 0 (ReLU) -> FC2 outputs 0 -> all f bytes 0.
- mem_sel=0 with d banks preloaded and c banks zeroed: results depend only on d; no c reads affect output.
- Activations 127, weights 7: acc 711200 -> saturates to 127 per FC1 byte.
- Golden pattern: compare e0-e4 addresses 0-24 and f addresses 0-2 against the software model. Check fc1_done within 20,100 cycles of conv_done, and fc2_done within 300 cycles after fc1_done.
- srstn asserted at cycle 5000 of FC1: next cycle both done flags 0 and write enables 1. A new conv_done reruns and produces the identical result.
